vga_capture: RTL

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_capture_if.sv | 27 ++
 rtl/vga_sync_counter.sv | 57 +++++
 rtl/vga_capture.sv | 114 +++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pixel and FSM types for capture and timing generation.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int SYNC_POL_DEF = 0;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } cap_state_t;

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_capture_if.sv
// Video-in and captured-pixel bundle between a VGA source and the capture block.
interface vga_capture_if;
    import vga_pkg::*;

    logic       vga_in_hs;
    logic       vga_in_vs;
    logic [4:0] vga_in_r;
    logic [5:0] vga_in_g;
    logic [4:0] vga_in_b;

    logic       px_valid;
    logic [9:0] px_x;
    logic [9:0] px_y;
    rgb565_t    px_data;
    logic       px_sof;
    logic       px_eol;

    modport master (
        input  vga_in_hs, vga_in_vs, vga_in_r, vga_in_g, vga_in_b,
        output px_valid, px_x, px_y, px_data, px_sof, px_eol
    );

    modport slave (
        output vga_in_hs, vga_in_vs, vga_in_r, vga_in_g, vga_in_b,
        input  px_valid, px_x, px_y, px_data, px_sof, px_eol
    );
endinterface

// File: rtl/vga_sync_counter.sv
// Sync edge detection plus line/frame position counters, advanced only on pix_en samples.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int SYNC_POL = SYNC_POL_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hs,
    input  logic        vs,
    output logic        smp,
    output logic        hs_edge,
    output logic        vs_edge,
    output logic [10:0] hcnt,
    output logic [10:0] h_meas,
    output logic [9:0]  vcnt,
    output logic [9:0]  v_meas
);
    localparam logic ACT = (SYNC_POL != 0);

    // History holds the "was active" flag, so reset means "inactive".
    logic hs_prev, vs_prev;
    logic hs_e, vs_e;

    assign hs_e = (hs == ACT) && !hs_prev;
    assign vs_e = (vs == ACT) && !vs_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp     <= 1'b0;
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            hs_edge <= 1'b0;
            vs_edge <= 1'b0;
            hcnt    <= '0;
            vcnt    <= '0;
            h_meas  <= '0;
            v_meas  <= '0;
        end else begin
            smp <= pix_en;
            if (pix_en) begin
                hs_prev <= (hs == ACT);
                vs_prev <= (vs == ACT);
                hs_edge <= hs_e;
                vs_edge <= vs_e;
                hcnt    <= hs_e ? 11'd0 : sat_inc11(hcnt);
                if (vs_e)
                    vcnt <= '0;
                else if (hs_e)
                    vcnt <= sat_inc10(vcnt);
                if (hs_e) h_meas <= hcnt + 11'd1;
                if (vs_e) v_meas <= vcnt + 10'd1;
            end
        end
    end
endmodule

// File: rtl/vga_capture.sv
// VGA capture: locks onto the configured timing and emits active-window pixels as RGB565.
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int SYNC_POL = SYNC_POL_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    vga_capture_if.master vif,
    output logic          locked,
    output logic [10:0]   h_meas,
    output logic [9:0]    v_meas,
    output logic [7:0]    err_cnt
);
    localparam int          H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
    localparam logic [9:0]  V_TOT   = 10'(V_TOTAL);
    localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

    logic        smp, hs_edge, vs_edge;
    logic [10:0] hcnt;
    logic [9:0]  vcnt;

    vga_sync_counter #(.SYNC_POL(SYNC_POL)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en),
        .hs     (vif.vga_in_hs),
        .vs     (vif.vga_in_vs),
        .smp    (smp),
        .hs_edge(hs_edge),
        .vs_edge(vs_edge),
        .hcnt   (hcnt),
        .h_meas (h_meas),
        .vcnt   (vcnt),
        .v_meas (v_meas)
    );

    cap_state_t state_q, state_d;
    logic       frame_ok, lose, h_bad, v_bad, in_win;
    rgb565_t    rgb_q;

    // Everything downstream works on the sample registered one clk earlier.
    assign h_bad = hs_edge && (h_meas != H_TOT);
    assign v_bad = vs_edge && (v_meas != V_TOT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_SEARCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEARCH:  if (smp && vs_edge) state_d = ST_MEASURE;
            ST_MEASURE: if (smp && vs_edge && frame_ok && !h_bad && !v_bad) state_d = ST_LOCKED;
            ST_LOCKED:  if (smp && (h_bad || v_bad || hcnt == 11'h7FF)) state_d = ST_SEARCH;
            default:    state_d = ST_SEARCH;
        endcase
    end

    always_comb begin
        locked = (state_q == ST_LOCKED);
        lose   = locked && (state_d == ST_SEARCH);
    end

    assign in_win = smp && locked &&
                    (hcnt >= H_START) && (hcnt <= H_END) &&
                    (vcnt >= V_START) && (vcnt <= V_END);

    // frame_ok covers every line closed since the last vsync edge, so it
    // rearms at vsync and the closing line is folded in via h_bad.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_ok     <= 1'b0;
            err_cnt      <= '0;
            rgb_q        <= '0;
            vif.px_valid <= 1'b0;
            vif.px_x     <= '0;
            vif.px_y     <= '0;
            vif.px_data  <= '0;
            vif.px_sof   <= 1'b0;
            vif.px_eol   <= 1'b0;
        end else begin
            if (smp) begin
                if (vs_edge)    frame_ok <= 1'b1;
                else if (h_bad) frame_ok <= 1'b0;
            end
            if (lose && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (pix_en) rgb_q <= {vif.vga_in_r, vif.vga_in_g, vif.vga_in_b};
            vif.px_valid <= in_win;
            vif.px_sof   <= in_win && (hcnt == H_START) && (vcnt == V_START);
            vif.px_eol   <= in_win && (hcnt == H_END);
            if (in_win) begin
                vif.px_x    <= 10'(hcnt - H_START);
                vif.px_y    <= vcnt - V_START;
                vif.px_data <= rgb_q;
            end
        end
    end
endmodule
